// File: rtl/chan_ram_ctrl.sv
// chan_ram_ctrl
//   Wraps one simple dual-port RAM (one write port, one registered read port,
//   1-cycle read latency) as a two-writer, one-reader channel FIFO. Arbitrates
//   the two producers onto the RAM write port, tracks pointers and occupancy,
//   and steers the RAM read address so the head entry is always on the read port.
//
// Build option:
//   CHAN_CTRL_RR_ARB_EN  defined   -> round-robin between writers on a tie
//                        undefined -> fixed priority, writer 0 wins a tie
//
// Ports:
//   clock, rstn                     clock, async active-low reset
//   wr0_valid/wr0_data/wr0_ready    producer 0 handshake
//   wr1_valid/wr1_data/wr1_ready    producer 1 handshake
//   rd_valid/rd_data/rd_ready       consumer handshake (rd_data = RAM output)
//   ram_write_en/ram_write_addr/ram_input_data   RAM write port
//   ram_read_addr/ram_output_data               RAM read port
//   count                           entries held (0..DEPTH)

module chan_ram_ctrl #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  wr0_valid,
    input  logic [DATA_WIDTH-1:0] wr0_data,
    output logic                  wr0_ready,
    input  logic                  wr1_valid,
    input  logic [DATA_WIDTH-1:0] wr1_data,
    output logic                  wr1_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [DATA_WIDTH-1:0] ram_input_data,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    input  logic [DATA_WIDTH-1:0] ram_output_data,
    output logic [ADDR_WIDTH:0]   count
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  last_grant;
    logic                  rd_valid_q;
    logic                  pend;

    logic                  full;
    logic                  grant0;
    logic                  grant1;
    logic                  push;
    logic                  pop;
    logic [CW-1:0]         count_next;
    logic                  rd_valid_next;

    // Fullness is taken from the registered count only, so a pop this cycle
    // does not open a slot until the next cycle.
    assign full = (count_q == CW'(DEPTH));

    // Readies are held low while rstn is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rstn && !full) begin
            if (wr0_valid && wr1_valid) begin
`ifdef CHAN_CTRL_RR_ARB_EN
                if (last_grant) grant0 = 1'b1;
                else            grant1 = 1'b1;
`else
                grant0 = 1'b1;
`endif
            end else if (wr0_valid) begin
                grant0 = 1'b1;
            end else if (wr1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

`ifndef CHAN_CTRL_RR_ARB_EN
    // last_grant is still tracked in fixed-priority builds but has no reader.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    assign push = grant0 | grant1;
    assign pop  = rd_valid_q & rd_ready;

    assign wr0_ready      = grant0;
    assign wr1_ready      = grant1;
    assign ram_write_en   = push;
    assign ram_write_addr = wr_ptr;
    assign ram_input_data = grant1 ? wr1_data : wr0_data;

    // Look one slot ahead on a pop so the new head is registered by the RAM
    // at this edge and rd_data has no bubble.
    assign ram_read_addr = pop ? (rd_ptr + ADDR_WIDTH'(1)) : rd_ptr;

    assign count_next = count_q + CW'(push) - CW'(pop);

    // An entry pushed this cycle is not readable at the next edge, so only
    // entries already in memory count. pend covers the one written last
    // cycle, which the RAM registers at this edge.
    assign rd_valid_next = pend | (count_q > CW'(pop));

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            last_grant <= 1'b1;
            rd_valid_q <= 1'b0;
            pend       <= 1'b0;
        end else begin
            count_q    <= count_next;
            rd_valid_q <= rd_valid_next;
            pend       <= push;
            if (push) begin
                wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
                last_grant <= grant1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = ram_output_data;
    assign count    = count_q;

endmodule

// File: tb/tb_chan_ram_ctrl.sv
// Directed bench for chan_ram_ctrl with a behavioural 8x32 RAM
// (registered read). Honours CHAN_CTRL_RR_ARB_EN for tie expectations.

module tb_chan_ram_ctrl;

    localparam int AW = 3;
    localparam int DW = 32;

    logic          clock;
    logic          rstn;
    logic          wr0_valid, wr1_valid;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_ready, wr1_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          ram_write_en;
    logic [AW-1:0] ram_write_addr;
    logic [DW-1:0] ram_input_data;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] ram_output_data;
    logic [AW:0]   count;

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [8];
    logic [DW-1:0] exp_q [8];

    chan_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock           (clock),
        .rstn            (rstn),
        .wr0_valid       (wr0_valid),
        .wr0_data        (wr0_data),
        .wr0_ready       (wr0_ready),
        .wr1_valid       (wr1_valid),
        .wr1_data        (wr1_data),
        .wr1_ready       (wr1_ready),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .rd_ready        (rd_ready),
        .ram_write_en    (ram_write_en),
        .ram_write_addr  (ram_write_addr),
        .ram_input_data  (ram_input_data),
        .ram_read_addr   (ram_read_addr),
        .ram_output_data (ram_output_data),
        .count           (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_input_data;
        ram_output_data <= mem[ram_read_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic g1;
        rstn      = 1'b0;
        wr0_valid = 1'b1;
        wr1_valid = 1'b1;
        wr0_data  = '0;
        wr1_data  = '0;
        rd_ready  = 1'b0;

        // Reset state, readies held low even with valids high.
        #3;
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr0_ready", wr0_ready, 0);
        chk("rst_wr1_ready", wr1_ready, 0);
        chk("rst_wen", ram_write_en, 0);
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        #14 rstn = 1'b1;
        tick();

        // Tie arbitration with streaming reads.
        for (int i = 0; i < 6; i++) begin
`ifdef CHAN_CTRL_RR_ARB_EN
            g1 = (i % 2) == 1;
`else
            g1 = 1'b0;
`endif
            wr0_valid = 1'b1; wr0_data = 32'h100 + i;
            wr1_valid = 1'b1; wr1_data = 32'h200 + i;
            rd_ready  = 1'b1;
            exp_q[i]  = g1 ? 32'h200 + i : 32'h100 + i;
            #1;
            chk("tie_wr0_ready", wr0_ready, !g1);
            chk("tie_wr1_ready", wr1_ready, g1);
            chk("tie_wdata", ram_input_data, exp_q[i]);
            if (i >= 2) begin
                chk("tie_rd_valid", rd_valid, 1);
                chk("tie_rd_data", rd_data, exp_q[i-2]);
            end
            tick();
        end
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        for (int i = 6; i < 8; i++) begin
            #1;
            chk("tie_tail_valid", rd_valid, 1);
            chk("tie_tail_data", rd_data, exp_q[i-2]);
            tick();
        end
        chk("tie_end_valid", rd_valid, 0);
        chk("tie_end_count", count, 0);
        rd_ready = 1'b0;

        // Single push: 2-cycle latency to rd_valid.
        wr0_valid = 1'b1; wr0_data = 32'hA5A5A5A5;
        #1;
        chk("sp_wr0_ready", wr0_ready, 1);
        chk("sp_wen", ram_write_en, 1);
        chk("sp_wdata", ram_input_data, 32'hA5A5A5A5);
        tick();
        wr0_valid = 1'b0;
        #1;
        chk("sp_count", count, 1);
        chk("sp_rd_valid_early", rd_valid, 0);
        tick();
        chk("sp_rd_valid", rd_valid, 1);
        chk("sp_rd_data", rd_data, 32'hA5A5A5A5);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("sp_pop_valid", rd_valid, 0);
        chk("sp_pop_count", count, 0);

        // Fill to full through writer 1, then drain.
        for (int i = 1; i <= 8; i++) begin
            wr1_valid = 1'b1; wr1_data = i;
            #1;
            chk("fill_wr1_ready", wr1_ready, 1);
            tick();
        end
        wr0_valid = 1'b1;
        #1;
        chk("full_count", count, 8);
        chk("full_wr0_ready", wr0_ready, 0);
        chk("full_wr1_ready", wr1_ready, 0);
        chk("full_wen", ram_write_en, 0);
        wr0_valid = 1'b0;
        wr1_valid = 1'b0;
        rd_ready  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", rd_data, i);
            tick();
        end
        chk("drain_end_valid", rd_valid, 0);
        chk("drain_end_count", count, 0);
        rd_ready = 1'b0;

        // Full with simultaneous pop: slot opens one cycle later.
        for (int i = 1; i <= 8; i++) begin
            wr0_valid = 1'b1; wr0_data = 32'h30 + i;
            tick();
        end
        wr0_data = 32'h77;
        rd_ready = 1'b1;
        #1;
        chk("fp_count8", count, 8);
        chk("fp_wr0_blocked", wr0_ready, 0);
        chk("fp_head", rd_data, 32'h31);
        tick();
        rd_ready = 1'b0;
        #1;
        chk("fp_count7", count, 7);
        chk("fp_wr0_open", wr0_ready, 1);
        tick();
        wr0_valid = 1'b0;
        #1;
        chk("fp_count_back", count, 8);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("fp_drain_valid", rd_valid, 1);
            chk("fp_drain_data", rd_data, (i < 7) ? 32'h32 + i : 32'h77);
            tick();
        end
        chk("fp_end_valid", rd_valid, 0);

        // Streaming across pointer rollover.
        for (int i = 0; i < 22; i++) begin
            wr0_valid = (i < 20);
            wr0_data  = 32'h500 + i;
            rd_ready  = 1'b1;
            #1;
            chk("wrap_count", count, (i == 0) ? 0 : (i == 1 || i == 21) ? 1 : 2);
            chk("wrap_valid", rd_valid, i >= 2);
            if (i >= 2) chk("wrap_data", rd_data, 32'h500 + i - 2);
            tick();
        end
        chk("wrap_end_valid", rd_valid, 0);
        chk("wrap_end_count", count, 0);
        wr0_valid = 1'b0;
        rd_ready  = 1'b0;

        // Asynchronous reset with 5 entries held.
        for (int i = 0; i < 5; i++) begin
            wr0_valid = 1'b1; wr0_data = 32'h40 + i;
            tick();
        end
        wr0_data = 32'h99;
        #1;
        chk("ar_count5", count, 5);
        chk("ar_ready_pre", wr0_ready, 1);
        #1 rstn = 1'b0;
        #1;
        chk("ar_rd_valid", rd_valid, 0);
        chk("ar_count", count, 0);
        chk("ar_wr0_ready", wr0_ready, 0);
        chk("ar_wen", ram_write_en, 0);
        #2;
        rstn      = 1'b1;
        wr0_valid = 1'b0;
        tick();
        wr0_valid = 1'b1; wr0_data = 32'hBEEF;
        #1;
        chk("ar_wr_addr", ram_write_addr, 0);
        chk("ar_push_ready", wr0_ready, 1);
        tick();
        wr0_valid = 1'b0;
        tick();
        chk("ar_new_valid", rd_valid, 1);
        chk("ar_new_data", rd_data, 32'hBEEF);
        chk("ar_new_count", count, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("ar_alone_valid", rd_valid, 0);
        chk("ar_alone_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
